// File: rtl/vga_pattern_gen.sv
// VGA sync timing plus four test patterns (bars, h-bars, checker, scroll); outputs registered one clock after the counters.
// Optional VGA_PATTERN_SCROLL_EN adds a per-frame counter so mode 3 scrolls; without it mode 3 shows mode 0.
module vga_pattern_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int COLOR_W   = 3,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         mode_sel,
  input  logic               mode_load,
  output logic [COLOR_W-1:0] pixel,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               frame_start,
  output logic [1:0]         active_mode
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);

  logic [XW-1:0]      h_cnt;
  logic [YW-1:0]      v_cnt;
  logic [1:0]         pending;
  logic [1:0]         cur_mode;
  logic               h_last;
  logic               v_last;
  logic               frame_end;
  logic               in_display;
  logic               hs_act;
  logic               vs_act;
  logic [COLOR_W-1:0] pat;

  assign h_last     = (int'(h_cnt) == H_TOTAL - 1);
  assign v_last     = (int'(v_cnt) == V_TOTAL - 1);
  assign frame_end  = h_last && v_last;
  assign in_display = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
  assign hs_act     = (int'(h_cnt) >= H_ACTIVE + H_FP) && (int'(h_cnt) < H_ACTIVE + H_FP + H_SYNC);
  assign vs_act     = (int'(v_cnt) >= V_ACTIVE + V_FP) && (int'(v_cnt) < V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // cur_mode drives pattern generation; active_mode is its copy aligned with the pixel outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= 2'd0;
      cur_mode <= 2'd0;
    end else begin
      if (mode_load) pending <= mode_sel;
      if (frame_end) cur_mode <= pending;
    end
  end

`ifdef VGA_PATTERN_SCROLL_EN
  logic [XW-1:0] frame_cnt;
  logic [XW-1:0] scroll_x;

  assign scroll_x = h_cnt + frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (frame_end) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    pat = '0;
    case (cur_mode)
      2'd0: pat = COLOR_W'(h_cnt >> 6);
      2'd1: pat = COLOR_W'(v_cnt >> 6);
      2'd2: pat = (h_cnt[5] ^ v_cnt[5]) ? {COLOR_W{1'b1}} : '0;
`ifdef VGA_PATTERN_SCROLL_EN
      default: pat = COLOR_W'(scroll_x >> 6);
`else
      default: pat = COLOR_W'(h_cnt >> 6);
`endif
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel       <= '0;
      hsync_out   <= ~HSYNC_POL;
      vsync_out   <= ~VSYNC_POL;
      frame_start <= 1'b0;
      active_mode <= 2'd0;
    end else begin
      pixel       <= in_display ? pat : '0;
      hsync_out   <= hs_act ? HSYNC_POL : ~HSYNC_POL;
      vsync_out   <= vs_act ? VSYNC_POL : ~VSYNC_POL;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      active_mode <= cur_mode;
    end
  end
endmodule
